// File: rtl/pe_mem_arbiter.sv
// Round-robin arbiter that shares one memory bus port among NUM_PE processing elements.
// Optional watchdog: define ARB_TIMEOUT_EN to end a stalled access after TIMEOUT cycles and flag err.
module pe_mem_arbiter #(
    parameter int NUM_PE  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_PE-1:0]        req_read,
    input  logic [NUM_PE-1:0]        req_write,
    input  logic [NUM_PE*DATA_W-1:0] req_addr,
    input  logic [NUM_PE*DATA_W-1:0] req_wdata,
    output logic [NUM_PE-1:0]        grant,
    output logic [NUM_PE-1:0]        done,
    output logic [DATA_W-1:0]        rdata,
    output logic [DATA_W-1:0]        bus_addr,
    output logic [DATA_W-1:0]        bus_wdata,
    output logic                     bus_read,
    output logic                     bus_write,
    input  logic                     bus_ack,
    input  logic [DATA_W-1:0]        bus_rdata,
    output logic                     busy,
    output logic                     err,
    output logic [1:0]               state_dbg
);

    // Handshakes: a PE raises req_read/req_write with addr/wdata and holds them until its
    // done pulse, dropping them the cycle after (a request still high in the next IDLE cycle
    // is a new request). On the bus side bus_read/bus_write and bus_addr/bus_wdata stay
    // stable from the cycle after the grant until the first cycle bus_ack is sampled high.

    localparam int IDX_W = $clog2(NUM_PE);

    if (NUM_PE < 2 || NUM_PE > 8 || DATA_W < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("pe_mem_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_PE-1:0]   grant_q, grant_d;
    logic [NUM_PE-1:0]   done_q, done_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;

    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic [IDX_W:0]      scan_sum;
    logic [IDX_W-1:0]    scan_idx;
    logic [DATA_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_wr;

`ifdef ARB_TIMEOUT_EN
    localparam int TCNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic                err_q, err_d;
`endif

    // Scan requesters starting at rr_ptr, wrapping modulo NUM_PE; the first hit wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
            if (scan_sum >= (IDX_W + 1)'(NUM_PE)) begin
                scan_sum = scan_sum - (IDX_W + 1)'(NUM_PE);
            end
            scan_idx = scan_sum[IDX_W-1:0];
            if (!win_found && (req_read[scan_idx] || req_write[scan_idx])) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (win_idx == IDX_W'(i)) begin
                sel_addr  = req_addr[i*DATA_W +: DATA_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_wr    = req_write[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        done_d   = '0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
`ifdef ARB_TIMEOUT_EN
        tcnt_d   = tcnt_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = ACCESS;
                    idx_d   = win_idx;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    // A PE asserting both read and write is served as a write.
                    wr_d    = sel_wr;
                    rd_d    = !sel_wr;
                    grant_d = NUM_PE'(1) << win_idx;
`ifdef ARB_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                end
            end
            ACCESS: begin
                if (bus_ack) begin
                    state_d = DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    done_d  = grant_q;
                    if (rd_q) begin
                        rdata_d = bus_rdata;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    done_d  = grant_q;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    tcnt_d  = tcnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                state_d  = IDLE;
                grant_d  = '0;
                rr_ptr_d = (idx_q == IDX_W'(NUM_PE - 1)) ? '0 : idx_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tcnt_q   <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
`ifdef ARB_TIMEOUT_EN
            tcnt_q   <= tcnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_read  = rd_q;
    assign bus_write = wr_q;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;
`ifdef ARB_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_pe_mem_arbiter.sv
// Self-checking bench for pe_mem_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level round-robin model.
module tb_pe_mem_arbiter;

    localparam int NUM_PE = 4;
    localparam int DATA_W = 32;
`ifdef ARB_TIMEOUT_EN
    localparam int TIMEOUT = 4;
`else
    localparam int TIMEOUT = 255;
`endif

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_PE-1:0]        req_read;
    logic [NUM_PE-1:0]        req_write;
    logic [NUM_PE*DATA_W-1:0] req_addr;
    logic [NUM_PE*DATA_W-1:0] req_wdata;
    logic [NUM_PE-1:0]        grant;
    logic [NUM_PE-1:0]        done;
    logic [DATA_W-1:0]        rdata;
    logic [DATA_W-1:0]        bus_addr;
    logic [DATA_W-1:0]        bus_wdata;
    logic                     bus_read;
    logic                     bus_write;
    logic                     bus_ack;
    logic [DATA_W-1:0]        bus_rdata;
    logic                     busy;
    logic                     err;
    logic [1:0]               state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: pending request table per PE, round-robin pointer, last read data.
    logic              pend[NUM_PE];
    logic              pend_rd[NUM_PE];
    logic              pend_wr[NUM_PE];
    logic [DATA_W-1:0] pend_addr[NUM_PE];
    logic [DATA_W-1:0] pend_wdata[NUM_PE];
    int                rr_m;
    logic [DATA_W-1:0] rdata_m;
    logic [DATA_W-1:0] exp_q[$];

    pe_mem_arbiter #(.NUM_PE(NUM_PE), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .grant(grant), .done(done), .rdata(rdata),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_read(bus_read), .bus_write(bus_write),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .busy(busy), .err(err), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_reqs();
        for (int i = 0; i < NUM_PE; i++) begin
            req_read[i]  = pend[i] & pend_rd[i];
            req_write[i] = pend[i] & pend_wr[i];
            req_addr[i*DATA_W +: DATA_W]  = pend_addr[i];
            req_wdata[i*DATA_W +: DATA_W] = pend_wdata[i];
        end
    endtask

    task automatic set_pe(input int i, input logic rd, input logic wr,
                          input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] w);
        pend[i]       = rd | wr;
        pend_rd[i]    = rd;
        pend_wr[i]    = wr;
        pend_addr[i]  = a;
        pend_wdata[i] = w;
        drive_reqs();
    endtask

    task automatic clear_all();
        for (int i = 0; i < NUM_PE; i++) pend[i] = 1'b0;
        drive_reqs();
    endtask

    task automatic new_random_req(input int i);
        int kind;
        kind = $urandom_range(0, 2);
        set_pe(i, kind != 1, kind != 0, $urandom, $urandom);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        bus_ack = 1'b0;
        clear_all();
        tick();
        reset   = 1'b0;
        rr_m    = 0;
        rdata_m = '0;
    endtask

    // Round-robin rule: first pending PE at rr, rr+1, ... modulo NUM_PE.
    function automatic int pick_winner(input int ptr);
        for (int k = 0; k < NUM_PE; k++) begin
            if (pend[(ptr + k) % NUM_PE]) return (ptr + k) % NUM_PE;
        end
        return -1;
    endfunction

    function automatic logic [NUM_PE-1:0] onehot(input int w);
        logic [NUM_PE-1:0] v;
        v = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        bus_ack = 1'b0;
        bus_rdata = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            pend[i] = 1'b0; pend_rd[i] = 1'b0; pend_wr[i] = 1'b0;
            pend_addr[i] = '0; pend_wdata[i] = '0;
        end
        drive_reqs();
        tick();
        tick();
        checks++;
        if (grant !== '0 || done !== '0) begin
            errors++; $display("FAIL reset_grant_done grant=%b done=%b expected 0", grant, done);
        end
        checks++;
        if (bus_read !== 1'b0 || bus_write !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL reset_strobes rd=%b wr=%b busy=%b err=%b expected 0", bus_read, bus_write, busy, err);
        end
        checks++;
        if (rdata !== '0 || bus_addr !== '0 || bus_wdata !== '0) begin
            errors++; $display("FAIL reset_data rdata=%h addr=%h wdata=%h expected 0", rdata, bus_addr, bus_wdata);
        end
        reset = 1'b0;
        rr_m = 0;
        rdata_m = '0;
    endtask

    task automatic test_single_read();
        set_pe(2, 1'b1, 1'b0, 32'h100, 32'h0);
        tick();
        checks++;
        if (grant !== 4'b0100 || bus_read !== 1'b1 || bus_write !== 1'b0 || bus_addr !== 32'h100 || busy !== 1'b1) begin
            errors++; $display("FAIL single_read_c1 grant=%b rd=%b wr=%b addr=%h busy=%b expected 0100 1 0 100 1", grant, bus_read, bus_write, bus_addr, busy);
        end
        tick();
        checks++;
        if (bus_read !== 1'b1 || done !== '0) begin
            errors++; $display("FAIL single_read_c2 rd=%b done=%b expected 1 0000", bus_read, done);
        end
        bus_ack = 1'b1;
        bus_rdata = 32'hDEADBEEF;
        tick();
        checks++;
        if (done !== 4'b0100 || rdata !== 32'hDEADBEEF || bus_read !== 1'b0 || grant !== 4'b0100) begin
            errors++; $display("FAIL single_read_done done=%b rdata=%h rd=%b grant=%b expected 0100 deadbeef 0 0100", done, rdata, bus_read, grant);
        end
        rdata_m = 32'hDEADBEEF;
        bus_ack = 1'b0;
        clear_all();
        rr_m = 3;
        tick();
        checks++;
        if (done !== '0 || grant !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_read_idle done=%b grant=%b busy=%b expected 0 0 0", done, grant, busy);
        end
    endtask

    task automatic test_fairness();
        int w;
        int start_prev;
        logic [DATA_W-1:0] v;
        do_reset();
        set_pe(0, 1'b1, 1'b0, 32'h10, 32'h0);
        set_pe(3, 1'b1, 1'b0, 32'h30, 32'h0);
        start_prev = -1;
        for (int n = 0; n < 4; n++) begin
            w = pick_winner(rr_m);
            tick();
            checks++;
            if (grant !== onehot(w) || bus_read !== 1'b1 || bus_addr !== pend_addr[w]) begin
                errors++; $display("FAIL fair_grant n=%0d grant=%b addr=%h expected %b %h", n, grant, bus_addr, onehot(w), pend_addr[w]);
            end
            if (start_prev >= 0) begin
                checks++;
                if (cyc - start_prev !== 3) begin
                    errors++; $display("FAIL fair_spacing n=%0d gap=%0d expected 3", n, cyc - start_prev);
                end
            end
            start_prev = cyc;
            v = $urandom;
            bus_ack = 1'b1;
            bus_rdata = v;
            tick();
            checks++;
            if (done !== onehot(w) || rdata !== v) begin
                errors++; $display("FAIL fair_done n=%0d done=%b rdata=%h expected %b %h", n, done, rdata, onehot(w), v);
            end
            rdata_m = v;
            bus_ack = 1'b0;
            rr_m = (w + 1) % NUM_PE;
            tick();
            checks++;
            if (grant !== '0 || busy !== 1'b0) begin
                errors++; $display("FAIL fair_idle n=%0d grant=%b busy=%b expected 0 0", n, grant, busy);
            end
        end
        clear_all();
    endtask

    task automatic test_read_write();
        set_pe(1, 1'b1, 1'b1, 32'h40, 32'h12345678);
        tick();
        checks++;
        if (grant !== 4'b0010 || bus_write !== 1'b1 || bus_read !== 1'b0 || bus_wdata !== 32'h12345678 || bus_addr !== 32'h40) begin
            errors++; $display("FAIL rw_access grant=%b wr=%b rd=%b wdata=%h addr=%h expected 0010 1 0 12345678 40", grant, bus_write, bus_read, bus_wdata, bus_addr);
        end
        bus_ack = 1'b1;
        bus_rdata = 32'hBAD0BAD0;
        tick();
        checks++;
        if (done !== 4'b0010 || rdata !== rdata_m) begin
            errors++; $display("FAIL rw_done done=%b rdata=%h expected 0010 %h", done, rdata, rdata_m);
        end
        bus_ack = 1'b0;
        clear_all();
        rr_m = 2;
        tick();
    endtask

    task automatic test_stray_ack();
        do_reset();
        bus_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus_rdata = $urandom;
            tick();
            checks++;
            if (done !== '0 || busy !== 1'b0 || grant !== '0 || bus_read !== 1'b0 || bus_write !== 1'b0 || rdata !== '0) begin
                errors++; $display("FAIL stray_ack c=%0d done=%b busy=%b grant=%b rd=%b wr=%b rdata=%h expected all 0", c, done, busy, grant, bus_read, bus_write, rdata);
            end
        end
        bus_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        set_pe(2, 1'b1, 1'b0, 32'h200, 32'h0);
        tick();
        bus_ack = 1'b1;
        bus_rdata = 32'h0000_2222;
        tick();
        bus_ack = 1'b0;
        clear_all();
        tick();
        set_pe(3, 1'b1, 1'b0, 32'h300, 32'h0);
        tick();
        tick();
        checks++;
        if (grant !== 4'b1000 || bus_read !== 1'b1) begin
            errors++; $display("FAIL reset_mid_setup grant=%b rd=%b expected 1000 1", grant, bus_read);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (grant !== '0 || bus_read !== 1'b0 || done !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid_clear grant=%b rd=%b done=%b busy=%b expected 0", grant, bus_read, done, busy);
        end
        rr_m = 0;
        rdata_m = '0;
        set_pe(1, 1'b1, 1'b0, 32'h100, 32'h0);
        tick();
        checks++;
        if (grant !== onehot(pick_winner(rr_m)) || done !== '0) begin
            errors++; $display("FAIL reset_mid_ptr grant=%b done=%b expected %b 0000", grant, done, onehot(pick_winner(rr_m)));
        end
        bus_ack = 1'b1;
        bus_rdata = 32'h1111_0001;
        tick();
        checks++;
        if (done !== 4'b0010 || rdata !== 32'h1111_0001) begin
            errors++; $display("FAIL reset_mid_done done=%b rdata=%h expected 0010 11110001", done, rdata);
        end
        rdata_m = 32'h1111_0001;
        bus_ack = 1'b0;
        clear_all();
        rr_m = 2;
        tick();
    endtask

    task automatic test_random();
        int w;
        int d;
        logic is_wr;
        logic [DATA_W-1:0] rd_val;
        logic [DATA_W-1:0] exp_rd;
        logic [NUM_PE-1:0] oh;
        for (int t = 0; t < 60; t++) begin
            bus_ack = 1'($urandom_range(0, 1));
            bus_rdata = $urandom;
            for (int i = 0; i < NUM_PE; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) new_random_req(i);
            end
            w = pick_winner(rr_m);
            if (w < 0) begin
                tick();
                checks++;
                if (grant !== '0 || busy !== 1'b0 || bus_read !== 1'b0 || bus_write !== 1'b0 || done !== '0) begin
                    errors++; $display("FAIL rand_idle t=%0d grant=%b busy=%b expected 0 0", t, grant, busy);
                end
                continue;
            end
            oh = onehot(w);
            is_wr = pend_wr[w];
            rd_val = $urandom;
            exp_q.push_back(is_wr ? rdata_m : rd_val);
            tick();
            checks++;
            if (grant !== oh || bus_read !== !is_wr || bus_write !== is_wr || bus_addr !== pend_addr[w] ||
                (is_wr && bus_wdata !== pend_wdata[w]) || busy !== 1'b1) begin
                errors++; $display("FAIL rand_access t=%0d grant=%b rd=%b wr=%b addr=%h expected %b %b %b %h", t, grant, bus_read, bus_write, bus_addr, oh, !is_wr, is_wr, pend_addr[w]);
            end
            d = $urandom_range(0, 3);
            for (int c = 0; c < d; c++) begin
                bus_ack = 1'b0;
                bus_rdata = $urandom;
                for (int i = 0; i < NUM_PE; i++) begin
                    if (i != w && !pend[i] && $urandom_range(0, 3) == 0) new_random_req(i);
                end
                tick();
                checks++;
                if (grant !== oh || bus_read !== !is_wr || bus_write !== is_wr || done !== '0) begin
                    errors++; $display("FAIL rand_hold t=%0d grant=%b rd=%b wr=%b done=%b expected %b %b %b 0", t, grant, bus_read, bus_write, done, oh, !is_wr, is_wr);
                end
            end
            bus_ack = 1'b1;
            bus_rdata = rd_val;
            tick();
            exp_rd = exp_q.pop_front();
            if (!is_wr) rdata_m = rd_val;
            checks++;
            if (done !== oh || grant !== oh || bus_read !== 1'b0 || bus_write !== 1'b0 || rdata !== exp_rd || err !== 1'b0) begin
                errors++; $display("FAIL rand_done t=%0d done=%b grant=%b rdata=%h err=%b expected %b %b %h 0", t, done, grant, rdata, err, oh, oh, exp_rd);
            end
            bus_ack = 1'($urandom_range(0, 1));
            pend[w] = 1'b0;
            drive_reqs();
            rr_m = (w + 1) % NUM_PE;
            tick();
            checks++;
            if (done !== '0 || grant !== '0 || busy !== 1'b0) begin
                errors++; $display("FAIL rand_release t=%0d done=%b grant=%b busy=%b expected 0", t, done, grant, busy);
            end
        end
        bus_ack = 1'b0;
        clear_all();
        tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        set_pe(0, 1'b0, 1'b1, 32'h80, 32'hCAFE0000);
        set_pe(2, 1'b1, 1'b0, 32'h84, 32'h0);
        for (int c = 1; c <= TIMEOUT; c++) begin
            tick();
            checks++;
            if (grant !== 4'b0001 || bus_write !== 1'b1 || done !== '0 || err !== 1'b0) begin
                errors++; $display("FAIL timeout_wait c=%0d grant=%b wr=%b done=%b err=%b expected 0001 1 0 0", c, grant, bus_write, done, err);
            end
        end
        tick();
        checks++;
        if (done !== 4'b0001 || err !== 1'b1 || bus_write !== 1'b0 || rdata !== '0) begin
            errors++; $display("FAIL timeout_done done=%b err=%b wr=%b rdata=%h expected 0001 1 0 0", done, err, bus_write, rdata);
        end
        pend[0] = 1'b0;
        drive_reqs();
        tick();
        checks++;
        if (err !== 1'b0 || done !== '0 || grant !== '0) begin
            errors++; $display("FAIL timeout_clear err=%b done=%b grant=%b expected 0", err, done, grant);
        end
        tick();
        checks++;
        if (grant !== 4'b0100 || bus_read !== 1'b1) begin
            errors++; $display("FAIL timeout_next grant=%b rd=%b expected 0100 1", grant, bus_read);
        end
        bus_ack = 1'b1;
        bus_rdata = 32'h5555AAAA;
        tick();
        bus_ack = 1'b0;
        clear_all();
        tick();
    endtask
`else
    task automatic test_no_timeout();
        int bad;
        do_reset();
        set_pe(0, 1'b0, 1'b1, 32'h80, 32'hCAFE0000);
        bad = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (grant !== 4'b0001 || bus_write !== 1'b1 || done !== '0 || err !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL no_timeout_hold bad_cycles=%0d expected 0", bad);
        end
        bus_ack = 1'b1;
        tick();
        checks++;
        if (done !== 4'b0001 || err !== 1'b0) begin
            errors++; $display("FAIL no_timeout_done done=%b err=%b expected 0001 0", done, err);
        end
        bus_ack = 1'b0;
        clear_all();
        tick();
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_read();
        test_fairness();
        test_read_write();
        test_stray_ack();
        test_reset_mid();
        test_random();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
